// File: rtl/updi_link_scheduler.sv
// UPDI link scheduler: arbitrates the single physical-level loader between the
// command generator (requester 0) and the debug/host port (requester 1), and
// sequences each transaction through TX, an optional guarded RX, and a report.
module updi_link_scheduler #(
  parameter int unsigned TIMEOUT_CYC = 4000,
  parameter int unsigned GUARD_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_rx,
  output logic [1:0] grant,
  output logic       busy,
  output logic       phy_ten_n,
  output logic       phy_ren_n,
  input  logic       phy_tdone,
  input  logic       phy_rdone,
  output logic       cmp_done,
  output logic       cmp_id,
  output logic       cmp_err
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);
  // A zero guard still spends one cycle with both enables released, so the
  // registered enables can never overlap across the turnaround.
  localparam int unsigned GuardLen = (GUARD_CYC == 0) ? 1 : GUARD_CYC;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [3:0] GuardLast = 4'(GuardLen - 1);

  typedef enum logic [2:0] {StIdle, StTx, StGuard, StRx, StDone} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        guard_q, guard_d;
  logic              owner_q, owner_d;
  logic              rx_pend_q, rx_pend_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic              win;

  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       ten_n_q, ten_n_d;
  logic       ren_n_q, ren_n_d;
  logic       cmp_done_q, cmp_done_d;
  logic       cmp_id_q, cmp_id_d;
  logic       cmp_err_q, cmp_err_d;

  // Round-robin winner: on contention pick the requester not served last.
  always_comb begin
    win = req_valid[1];
    if (req_valid == 2'b11) begin
      win = ~last_q;
    end
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      guard_q    <= '0;
      owner_q    <= 1'b0;
      rx_pend_q  <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= 1'b1;  // requester 0 wins first after reset
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
      ten_n_q    <= 1'b1;
      ren_n_q    <= 1'b1;
      cmp_done_q <= 1'b0;
      cmp_id_q   <= 1'b0;
      cmp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      guard_q    <= guard_d;
      owner_q    <= owner_d;
      rx_pend_q  <= rx_pend_d;
      err_q      <= err_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      ten_n_q    <= ten_n_d;
      ren_n_q    <= ren_n_d;
      cmp_done_q <= cmp_done_d;
      cmp_id_q   <= cmp_id_d;
      cmp_err_q  <= cmp_err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    guard_d   = guard_q;
    owner_d   = owner_q;
    rx_pend_d = rx_pend_q;
    err_d     = err_q;
    last_d    = last_q;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          state_d   = StTx;
          owner_d   = win;
          rx_pend_d = req_rx[win];
          err_d     = 1'b0;
          timer_d   = '0;
        end
      end
      StTx: begin
        timer_d = timer_q + 1'b1;
        // tdone takes priority over a coincident timeout
        if (phy_tdone) begin
          timer_d = '0;
          guard_d = '0;
          state_d = rx_pend_q ? StGuard : StDone;
        end else if (timer_q == TimerLast) begin
          timer_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StGuard: begin
        if (guard_q == GuardLast) begin
          timer_d = '0;
          state_d = StRx;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      StRx: begin
        timer_d = timer_q + 1'b1;
        if (phy_rdone) begin
          timer_d = '0;
          state_d = StDone;
        end else if (timer_q == TimerLast) begin
          timer_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    grant_d    = 2'b00;
    busy_d     = (state_d != StIdle);
    ten_n_d    = (state_d != StTx);
    ren_n_d    = (state_d != StRx);
    cmp_done_d = (state_d == StDone);
    cmp_id_d   = 1'b0;
    cmp_err_d  = 1'b0;
    if (state_d != StIdle) begin
      grant_d = owner_d ? 2'b10 : 2'b01;
    end
    if (state_d == StDone) begin
      cmp_id_d  = owner_d;
      cmp_err_d = err_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign phy_ten_n = ten_n_q;
  assign phy_ren_n = ren_n_q;
  assign cmp_done  = cmp_done_q;
  assign cmp_id    = cmp_id_q;
  assign cmp_err   = cmp_err_q;

endmodule

// File: tb/tb_updi_link_scheduler.sv
// Self-checking bench for updi_link_scheduler with a completion scoreboard.
module tb_updi_link_scheduler;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_rx;
  logic [1:0] grant;
  logic       busy;
  logic       phy_ten_n;
  logic       phy_ren_n;
  logic       phy_tdone;
  logic       phy_rdone;
  logic       cmp_done;
  logic       cmp_id;
  logic       cmp_err;

  int total = 0;
  int bad = 0;
  int mx_bad = 0;
  int mx_samples = 0;

  // Scoreboard of expected {cmp_id, cmp_err}
  logic [1:0] sb[$];

  updi_link_scheduler #(
    .TIMEOUT_CYC(16),
    .GUARD_CYC  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_rx   (req_rx),
    .grant    (grant),
    .busy     (busy),
    .phy_ten_n(phy_ten_n),
    .phy_ren_n(phy_ren_n),
    .phy_tdone(phy_tdone),
    .phy_rdone(phy_rdone),
    .cmp_done (cmp_done),
    .cmp_id   (cmp_id),
    .cmp_err  (cmp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enables must never be low together.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mx_samples++;
      if (phy_ten_n === 1'b0 && phy_ren_n === 1'b0) mx_bad++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays the loader: waits for TX, pulses tdone/rdone on the requested
  // cycle of each phase and records what the scheduler did until cmp_done.
  task automatic run_phy(input int tdone_at, input int rdone_at, input bit spur,
                         output int lat, output logic [1:0] gnt, output int ten_lo,
                         output int gap, output int ren_lo, output bit got,
                         output logic id, output logic err);
    lat = 0; gnt = 2'bxx; ten_lo = 0; gap = 0; ren_lo = 0; got = 0; id = 1'bx; err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (phy_ten_n === 1'b0) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) return;
    gnt = grant;
    for (int c = 0; c < 200; c++) begin
      if (cmp_done === 1'b1) begin
        got = 1; id = cmp_id; err = cmp_err;
        break;
      end
      if (phy_ten_n === 1'b0) begin
        ten_lo++;
        if (ten_lo == tdone_at) phy_tdone = 1'b1;
        if (spur && ten_lo == 2) phy_rdone = 1'b1;
      end else if (phy_ren_n === 1'b0) begin
        ren_lo++;
        if (ren_lo == rdone_at) phy_rdone = 1'b1;
      end else begin
        gap++;
      end
      step();
      phy_tdone = 1'b0;
      phy_rdone = 1'b0;
    end
  endtask

  task automatic check_cmp(input string name, input bit got, input logic id, input logic err);
    logic [1:0] exp;
    total++;
    if (!got || sb.size() == 0) begin
      bad++;
      $display("FAIL %s_cmp: got_done=%0d queued=%0d required done with queued entry",
               name, got, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      exp = sb.pop_front();
      if ({id, err} !== exp) begin
        bad++;
        $display("FAIL %s_cmp: id/err=%b%b required %b", name, id, err, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 2'b00; req_rx = 2'b00; phy_tdone = 1'b0; phy_rdone = 1'b0;
    step(); step();
    total++;
    if ({grant, busy, phy_ten_n, phy_ren_n, cmp_done, cmp_id, cmp_err} !== 8'b00011000) begin
      bad++;
      $display("FAIL reset_outputs: %b required 00011000",
               {grant, busy, phy_ten_n, phy_ren_n, cmp_done, cmp_id, cmp_err});
    end
    rst = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle: busy=%b grant=%b required 0/00", busy, grant);
    end
  endtask

  task automatic test_tx_only();
    int lat, tl, gp, rl; logic [1:0] g; bit got; logic id, err;
    req_valid = 2'b01; req_rx = 2'b00;
    sb.push_back(2'b00);
    run_phy(10, 0, 0, lat, g, tl, gp, rl, got, id, err);
    req_valid = 2'b00;
    total++;
    if (lat !== 1) begin bad++; $display("FAIL tx_latency: %0d required 1", lat); end
    total++;
    if (g !== 2'b01) begin bad++; $display("FAIL tx_grant: %b required 01", g); end
    total++;
    if (tl !== 10 || rl !== 0 || gp !== 0) begin
      bad++;
      $display("FAIL tx_phases: ten_lo=%0d ren_lo=%0d gap=%0d required 10/0/0", tl, rl, gp);
    end
    check_cmp("tx", got, id, err);
    step();
    total++;
    if (cmp_done !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tx_after: done=%b grant=%b busy=%b required 0/00/0", cmp_done, grant, busy);
    end
  endtask

  task automatic test_rx_guard();
    int lat, tl, gp, rl; logic [1:0] g; bit got; logic id, err;
    req_valid = 2'b10; req_rx = 2'b10;
    sb.push_back(2'b10);
    run_phy(3, 5, 0, lat, g, tl, gp, rl, got, id, err);
    req_valid = 2'b00; req_rx = 2'b00;
    total++;
    if (g !== 2'b10) begin bad++; $display("FAIL rx_grant: %b required 10", g); end
    total++;
    if (tl !== 3 || gp !== 2 || rl !== 5) begin
      bad++;
      $display("FAIL rx_phases: ten_lo=%0d gap=%0d ren_lo=%0d required 3/2/5", tl, gp, rl);
    end
    check_cmp("rx", got, id, err);
    step();
  endtask

  task automatic test_round_robin();
    int lat, tl, gp, rl; logic [1:0] g; bit got; logic id, err;
    logic [1:0] exp_g;
    req_valid = 2'b11; req_rx = 2'b00;
    for (int n = 0; n < 4; n++) begin
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      sb.push_back({exp_g[1], 1'b0});
      run_phy(1, 0, 0, lat, g, tl, gp, rl, got, id, err);
      total++;
      if (g !== exp_g || lat !== 1 || tl !== 1 || gp !== 0) begin
        bad++;
        $display("FAIL rr_txn%0d: grant=%b lat=%0d ten_lo=%0d gap=%0d required %b/1/1/0",
                 n, g, lat, tl, gp, exp_g);
      end
      check_cmp("rr", got, id, err);
      if (n == 3) req_valid = 2'b00;
      step();
      total++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rr_gap%0d: grant=%b busy=%b required 00/0", n, grant, busy);
      end
    end
  endtask

  task automatic test_timeout();
    int lat, tl, gp, rl; logic [1:0] g; bit got; logic id, err;
    req_valid = 2'b01; req_rx = 2'b00;
    sb.push_back(2'b01);
    run_phy(0, 0, 0, lat, g, tl, gp, rl, got, id, err);
    req_valid = 2'b00;
    total++;
    if (tl !== 16) begin bad++; $display("FAIL to_ten_lo: %0d required 16", tl); end
    check_cmp("to", got, id, err);
    step();
    req_valid = 2'b10;
    sb.push_back(2'b10);
    run_phy(2, 0, 0, lat, g, tl, gp, rl, got, id, err);
    req_valid = 2'b00;
    total++;
    if (g !== 2'b10 || tl !== 2) begin
      bad++;
      $display("FAIL to_next: grant=%b ten_lo=%0d required 10/2", g, tl);
    end
    check_cmp("to_next", got, id, err);
    step();
  endtask

  task automatic test_spurious();
    int lat, tl, gp, rl; logic [1:0] g; bit got; logic id, err;
    req_valid = 2'b01; req_rx = 2'b00;
    sb.push_back(2'b00);
    run_phy(16, 0, 1, lat, g, tl, gp, rl, got, id, err);
    req_valid = 2'b00;
    total++;
    if (tl !== 16 || rl !== 0) begin
      bad++;
      $display("FAIL spur_phases: ten_lo=%0d ren_lo=%0d required 16/0", tl, rl);
    end
    check_cmp("spur", got, id, err);
    step();
  endtask

  task automatic test_mid_reset();
    int lat, tl, gp, rl; logic [1:0] g; bit got; logic id, err;
    bit seen;
    // Requester 0 served last, so without reset requester 1 would win next.
    req_valid = 2'b01; req_rx = 2'b00;
    sb.push_back(2'b00);
    run_phy(1, 0, 0, lat, g, tl, gp, rl, got, id, err);
    check_cmp("pre_rst", got, id, err);
    step();
    req_rx = 2'b01;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (phy_ten_n === 1'b0) phy_tdone = 1'b1;
      if (phy_ren_n === 1'b0) begin seen = 1; break; end
      if (phy_ten_n !== 1'b0) phy_tdone = 1'b0;
    end
    phy_tdone = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL mr_reach_rx: ren_n never low required low"); end
    step();
    rst = 1'b0;
    step();
    total++;
    if ({grant, busy, phy_ten_n, phy_ren_n, cmp_done, cmp_id, cmp_err} !== 8'b00011000) begin
      bad++;
      $display("FAIL mr_outputs: %b required 00011000",
               {grant, busy, phy_ten_n, phy_ren_n, cmp_done, cmp_id, cmp_err});
    end
    rst = 1'b1;
    req_valid = 2'b11; req_rx = 2'b00;
    sb.push_back(2'b00);
    run_phy(1, 0, 0, lat, g, tl, gp, rl, got, id, err);
    req_valid = 2'b00;
    total++;
    if (g !== 2'b01) begin bad++; $display("FAIL mr_first_grant: %b required 01", g); end
    check_cmp("mr", got, id, err);
    step();
  endtask

  task automatic test_mutex();
    total++;
    if (mx_bad !== 0 || mx_samples == 0) begin
      bad++;
      $display("FAIL mutex: overlaps=%0d samples=%0d required 0 overlaps", mx_bad, mx_samples);
    end
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_tx_only();
    test_rx_guard();
    test_round_robin();
    test_timeout();
    test_spurious();
    test_mid_reset();
    test_mutex();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
